// File: rtl/regfile_mp.sv
// Multi-read, single-write register file with sequential clear after reset, optional zero register and write bypass.
// Latency: reads are combinational (0 cycles); writes land at the next rising edge; clear takes DEPTH cycles.
// Backpressure: none; writes arriving while the clear walk runs are discarded and flagged on wr_drop.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   we/waddr/wdata  single write port
//   raddr/rdata   NRD packed read ports, port k at [k*AW +: AW] / [k*DW +: DW]
//   ready         high once every entry has been cleared
//   wr_drop       one-cycle registered pulse when a write was discarded during clear
module regfile_mp #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DW-1:0]       wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*DW-1:0]   rdata,
    output logic                ready,
    output logic                wr_drop
);

    if (DEPTH < 2) begin : g_bad_depth
        $error("regfile_mp: DEPTH must be at least 2");
    end
    if (NRD < 1) begin : g_bad_nrd
        $error("regfile_mp: NRD must be at least 1");
    end

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [AW-1:0]  clr_cnt, clr_cnt_nxt;
    logic [DW-1:0]  rf [DEPTH];

    // Address range qualifiers: only a non-power-of-two DEPTH can see
    // addresses past the last entry, so the full case needs no compare.
    logic            w_ok;
    logic [NRD-1:0]  r_ok;

    if (DEPTH == (1 << AW)) begin : g_full
        assign w_ok = 1'b1;
        assign r_ok = '1;
    end else begin : g_part
        assign w_ok = (32'(waddr) < DEPTH);
        for (genvar k = 0; k < NRD; k++) begin : g_rok
            assign r_ok[k] = (32'(raddr[k*AW +: AW]) < DEPTH);
        end
    end

    logic wr_zero;
    assign wr_zero = (ZERO_REG != 0) && (waddr == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next state: walk the counter through every entry, then go READY
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        if (state == CLEAR) begin
            if (clr_cnt == AW'(DEPTH - 1)) begin
                state_nxt   = READY;
                clr_cnt_nxt = '0;
            end else begin
                clr_cnt_nxt = clr_cnt + 1'b1;
            end
        end
    end

    assign ready = (state == READY);

    // Array: the clear walk owns the write port until READY; the reset
    // cycle itself leaves contents alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                rf[clr_cnt] <= '0;
            end else if (we && w_ok && !wr_zero) begin
                rf[waddr] <= wdata;
            end
        end
    end

    // Only user writes swallowed by the clear walk are reported; zero
    // register and out-of-range writes are silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= (state == CLEAR) && we;
        end
    end

    // Read ports: zero register beats bypass; nothing is visible until ready.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0] ra;
            ra = raddr[k*AW +: AW];
            if (!ready || !r_ok[k]) begin
                rdata[k*DW +: DW] = '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rdata[k*DW +: DW] = '0;
            end else if ((BYPASS != 0) && we && (waddr == ra)) begin
                rdata[k*DW +: DW] = wdata;
            end else begin
                rdata[k*DW +: DW] = rf[ra];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata_b, rdata_n;
    logic        ready_b, ready_n, drop_b, drop_n;

    int vecs = 0;
    int errs = 0;
    logic [31:0] model [32];
    logic [31:0] sb [$];
    logic [31:0] exp;

    always #5 clk = ~clk;

    regfile_mp #(.DW(32), .DEPTH(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .ready(ready_b), .wr_drop(drop_b)
    );

    regfile_mp #(.DW(32), .DEPTH(32), .NRD(2), .ZERO_REG(1), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_n), .ready(ready_n), .wr_drop(drop_n)
    );

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1; we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready_b !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        pulse_rst();
        if (ready_b !== 1'b0 || drop_b !== 1'b0 || rdata_b !== 64'd0) begin
            $display("FAIL reset_state ready=%b drop=%b rdata=%h required 0/0/0", ready_b, drop_b, rdata_b);
            errs++;
        end
        vecs++;
        wait_ready(n);
        if (n !== 32) begin
            $display("FAIL reset_clear_cycles got %0d required 32", n);
            errs++;
        end
        vecs++;
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            raddr = {5'(31 - a), 5'(a)};
            sb.push_back(model[a]);
            sb.push_back(model[31 - a]);
            #1;
            exp = sb.pop_front();
            if (rdata_b[31:0] !== exp) begin
                $display("FAIL reset_read p0 a=%0d got %h required %h", a, rdata_b[31:0], exp);
                errs++;
            end
            vecs++;
            exp = sb.pop_front();
            if (rdata_b[63:32] !== exp) begin
                $display("FAIL reset_read p1 a=%0d got %h required %h", 31 - a, rdata_b[63:32], exp);
                errs++;
            end
            vecs++;
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd5, 5'd5};
        sb.push_back(model[5]);
        sb.push_back(32'hDEADBEEF);
        #1;
        exp = sb.pop_front();
        if (rdata_n[31:0] !== exp) begin
            $display("FAIL nobypass_same_cycle got %h required %h", rdata_n[31:0], exp);
            errs++;
        end
        vecs++;
        exp = sb.pop_front();
        if (rdata_b[31:0] !== exp) begin
            $display("FAIL bypass_same_cycle_a5 got %h required %h", rdata_b[31:0], exp);
            errs++;
        end
        vecs++;
        model[5] = 32'hDEADBEEF;
        @(negedge clk);
        we = 1'b0;
        sb.push_back(model[5]);
        sb.push_back(model[5]);
        #1;
        exp = sb.pop_front();
        if (rdata_n[31:0] !== exp) begin
            $display("FAIL nobypass_next_p0 got %h required %h", rdata_n[31:0], exp);
            errs++;
        end
        vecs++;
        exp = sb.pop_front();
        if (rdata_n[63:32] !== exp) begin
            $display("FAIL nobypass_next_p1 got %h required %h", rdata_n[63:32], exp);
            errs++;
        end
        vecs++;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we = 1'b1; waddr = 5'd3; wdata = 32'hCAFE0003;
        model[3] = 32'hCAFE0003;
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; raddr = {5'd3, 5'd7};
        sb.push_back(32'h12345678);
        sb.push_back(model[3]);
        sb.push_back(model[7]);
        #1;
        exp = sb.pop_front();
        if (rdata_b[31:0] !== exp) begin
            $display("FAIL bypass_p0 got %h required %h", rdata_b[31:0], exp);
            errs++;
        end
        vecs++;
        exp = sb.pop_front();
        if (rdata_b[63:32] !== exp) begin
            $display("FAIL bypass_p1_other got %h required %h", rdata_b[63:32], exp);
            errs++;
        end
        vecs++;
        exp = sb.pop_front();
        if (rdata_n[31:0] !== exp) begin
            $display("FAIL nobypass_old_a7 got %h required %h", rdata_n[31:0], exp);
            errs++;
        end
        vecs++;
        model[7] = 32'h12345678;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr = {5'd0, 5'd0};
        sb.push_back(32'd0);
        #1;
        exp = sb.pop_front();
        if (rdata_b[31:0] !== exp || rdata_n[31:0] !== exp) begin
            $display("FAIL zero_same_cycle got %h/%h required %h", rdata_b[31:0], rdata_n[31:0], exp);
            errs++;
        end
        vecs++;
        @(negedge clk);
        we = 1'b0;
        sb.push_back(32'd0);
        #1;
        exp = sb.pop_front();
        if (rdata_b[31:0] !== exp || rdata_n[63:32] !== exp || drop_b !== 1'b0) begin
            $display("FAIL zero_after got %h/%h drop=%b required %h drop=0", rdata_b[31:0], rdata_n[63:32], drop_b, exp);
            errs++;
        end
        vecs++;
    endtask

    task automatic test_random_ports();
        logic [4:0]  wa, r0, r1;
        logic [31:0] wd;
        logic        w;
        logic [31:0] e0, e1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            w  = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            r0 = (c % 4 == 0) ? wa : 5'($urandom_range(0, 31));
            r1 = (c % 5 == 0) ? r0 : 5'($urandom_range(0, 31));
            we = w; waddr = wa; wdata = wd; raddr = {r1, r0};
            e0 = (r0 == 0) ? 32'd0 : (w && wa == r0) ? wd : model[r0];
            e1 = (r1 == 0) ? 32'd0 : (w && wa == r1) ? wd : model[r1];
            sb.push_back(e0);
            sb.push_back(e1);
            sb.push_back((r0 == 0) ? 32'd0 : model[r0]);
            #1;
            exp = sb.pop_front();
            if (rdata_b[31:0] !== exp) begin
                $display("FAIL rand_b_p0 c=%0d a=%0d got %h required %h", c, r0, rdata_b[31:0], exp);
                errs++;
            end
            vecs++;
            exp = sb.pop_front();
            if (rdata_b[63:32] !== exp) begin
                $display("FAIL rand_b_p1 c=%0d a=%0d got %h required %h", c, r1, rdata_b[63:32], exp);
                errs++;
            end
            vecs++;
            exp = sb.pop_front();
            if (rdata_n[31:0] !== exp) begin
                $display("FAIL rand_n_p0 c=%0d a=%0d got %h required %h", c, r0, rdata_n[31:0], exp);
                errs++;
            end
            vecs++;
            if (drop_b !== 1'b0) begin
                $display("FAIL rand_drop c=%0d got %b required 0", c, drop_b);
                errs++;
            end
            vecs++;
            if (w && wa != 0) model[wa] = wd;
        end
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_write_during_clear();
        int n;
        pulse_rst();
        @(negedge clk);
        we = 1'b1; waddr = 5'd3; wdata = 32'hAA; raddr = {5'd5, 5'd3};
        #1;
        if (rdata_b !== 64'd0) begin
            $display("FAIL clear_reads_zero got %h required 0", rdata_b);
            errs++;
        end
        vecs++;
        @(negedge clk);
        we = 1'b0;
        #1;
        if (drop_b !== 1'b1 || drop_n !== 1'b1) begin
            $display("FAIL clear_drop_pulse got %b/%b required 1", drop_b, drop_n);
            errs++;
        end
        vecs++;
        step();
        if (drop_b !== 1'b0) begin
            $display("FAIL clear_drop_end got %b required 0", drop_b);
            errs++;
        end
        vecs++;
        wait_ready(n);
        for (int i = 0; i < 32; i++) model[i] = '0;
        @(negedge clk);
        raddr = {5'd5, 5'd3};
        sb.push_back(model[3]);
        #1;
        exp = sb.pop_front();
        if (ready_b !== 1'b1 || rdata_b[31:0] !== exp || rdata_b[63:32] !== 32'd0) begin
            $display("FAIL clear_drop_a3 ready=%b got %h/%h required %h/0", ready_b, rdata_b[31:0], rdata_b[63:32], exp);
            errs++;
        end
        vecs++;
    endtask

    task automatic test_reset_mid();
        int n;
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            we = 1'b1; waddr = 5'(a); wdata = 32'h01010101 * a + 32'h5A000000;
        end
        @(negedge clk);
        we = 1'b0;
        pulse_rst();
        repeat (9) @(negedge clk);
        pulse_rst();
        if (ready_b !== 1'b0) begin
            $display("FAIL mid_reset_ready got %b required 0", ready_b);
            errs++;
        end
        vecs++;
        wait_ready(n);
        if (n !== 32) begin
            $display("FAIL mid_reset_cycles got %0d required 32", n);
            errs++;
        end
        vecs++;
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            raddr = {5'(a), 5'(a)};
            sb.push_back(model[a]);
            #1;
            exp = sb.pop_front();
            if (rdata_n[31:0] !== exp || rdata_b[63:32] !== exp) begin
                $display("FAIL mid_reset_read a=%0d got %h/%h required %h", a, rdata_n[31:0], rdata_b[63:32], exp);
                errs++;
            end
            vecs++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_random_ports();
        test_write_during_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
